// File: rtl/sar_pkg.sv
// Shared constants and state encoding for the SAR conversion controller.
package sar_pkg;

  localparam int SAR_NBITS      = 10;
  localparam int SAR_SAMPLE_CYC = 2;
  localparam int SAR_CMP_WAIT   = 1;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    STROBE,
    WAIT,
    DECIDE,
    DONE
  } sar_state_t;

endpackage

// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: track, then one
// strobe/settle/decide round per bit, MSB first.
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int NBITS      = SAR_NBITS,
  parameter int SAMPLE_CYC = SAR_SAMPLE_CYC,
  parameter int CMP_WAIT   = SAR_CMP_WAIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_out,
  output logic             sample,
  output logic             cmp_en,
  output logic [NBITS-1:0] dac_code,
  output logic [NBITS-1:0] dout,
  output logic             busy,
  output logic             done
);

  localparam int PW   = $clog2(NBITS);
  localparam int CNTW = 16;

  sar_state_t       state, state_n;
  logic [CNTW-1:0]  cnt, cnt_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [NBITS-1:0] dac_n, dout_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      dac_code <= '0;
      dout     <= '0;
      sample   <= 1'b0;
      cmp_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      dac_code <= dac_n;
      dout     <= dout_n;
      // Strobes are registered copies of the state being entered.
      sample   <= (state_n == SAMPLE);
      cmp_en   <= (state_n == STROBE);
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    dac_n   = dac_code;
    dout_n  = dout;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SAMPLE;
          dac_n   = '0;
          cnt_n   = CNTW'(SAMPLE_CYC - 1);
        end
      end
      SAMPLE: begin
        if (cnt == '0) begin
          state_n          = STROBE;
          dac_n            = '0;
          dac_n[NBITS-1]   = 1'b1;
          ptr_n            = PW'(NBITS - 1);
        end else begin
          cnt_n = cnt - CNTW'(1);
        end
      end
      STROBE: begin
        if (CMP_WAIT == 0) begin
          state_n = DECIDE;
        end else begin
          state_n = WAIT;
          cnt_n   = CNTW'(CMP_WAIT - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = DECIDE;
        else           cnt_n   = cnt - CNTW'(1);
      end
      DECIDE: begin
        if (!cmp_out) dac_n[ptr] = 1'b0;
        if (ptr != '0) begin
          dac_n[ptr - PW'(1)] = 1'b1;
          ptr_n   = ptr - PW'(1);
          state_n = STROBE;
        end else begin
          state_n = DONE;
          dout_n  = dac_n;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sar_ctrl.sv
// Bench for sar_ctrl: vector table, scoreboard on done, and
// multi-cycle sequences for reset abort, held start and a small build.
module tb_sar_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cmp_out;
  logic       sample, cmp_en, busy, done;
  logic [9:0] dac_code, dout;

  logic       s_start = 1'b0;
  logic       s_cmp;
  logic       s_sample, s_cmp_en, s_busy, s_done;
  logic [3:0] s_dac, s_dout;

  logic [9:0] vin = '0;
  int         mode = 0;
  logic [3:0] s_vin = 4'hA;

  int compared = 0;
  int mismatched = 0;
  int done_seen = 0;
  int s_cmp_cnt = 0;
  logic prev_done = 1'b0;
  logic prev_s_done = 1'b0;

  logic [9:0] sb[$];
  logic [9:0] trial_q[$];

  typedef struct {
    int         mode;
    logic [9:0] vin;
    logic [9:0] exp;
    bit         trials;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  always_comb begin
    if (mode == 1)      cmp_out = 1'b1;
    else if (mode == 2) cmp_out = 1'b0;
    else                cmp_out = (vin >= dac_code);
  end

  assign s_cmp = (s_vin >= s_dac);

  sar_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .cmp_out(cmp_out),
    .sample(sample), .cmp_en(cmp_en), .dac_code(dac_code),
    .dout(dout), .busy(busy), .done(done)
  );

  sar_ctrl #(.NBITS(4), .SAMPLE_CYC(1), .CMP_WAIT(0)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .cmp_out(s_cmp),
    .sample(s_sample), .cmp_en(s_cmp_en), .dac_code(s_dac),
    .dout(s_dout), .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_done   <= 1'b0;
      prev_s_done <= 1'b0;
    end else begin
      chk("sample_and_cmp_en", {31'd0, sample & cmp_en}, 32'd0);
      chk("done_twice", {31'd0, done & prev_done}, 32'd0);
      chk("s_sample_and_cmp_en", {31'd0, s_sample & s_cmp_en}, 32'd0);
      chk("s_done_twice", {31'd0, s_done & prev_s_done}, 32'd0);
      prev_done   <= done;
      prev_s_done <= s_done;
      if (cmp_en) trial_q.push_back(dac_code);
      if (s_cmp_en) s_cmp_cnt++;
      if (done) begin
        done_seen++;
        if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else chk("sb_dout", {22'd0, dout}, {22'd0, sb.pop_front()});
      end
    end
  end

  task automatic run_conv(input int m, input logic [9:0] v,
                          input logic [9:0] exp);
    int lat;
    mode = m;
    vin  = v;
    trial_q.delete();
    sb.push_back(exp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 32);
    chk("dac_hold_at_done", {22'd0, dac_code}, {22'd0, exp});
    @(posedge clk); #1;
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d1, d2, lows, pulses, budget, dseen, lat;

    tbl[0] = '{0, 10'h2A5, 10'h2A5, 1'b0};
    tbl[1] = '{1, 10'h000, 10'h3FF, 1'b0};
    tbl[2] = '{2, 10'h3FF, 10'h000, 1'b1};
    tbl[3] = '{0, 10'h155, 10'h155, 1'b0};
    tbl[4] = '{0, 10'h000, 10'h000, 1'b0};
    tbl[5] = '{0, 10'h3FF, 10'h3FF, 1'b0};
    tbl[6] = '{0, 10'h001, 10'h001, 1'b0};
    tbl[7] = '{0, 10'h200, 10'h200, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sample", {31'd0, sample}, 32'd0);
    chk("rst_cmp_en", {31'd0, cmp_en}, 32'd0);
    chk("rst_dac", {22'd0, dac_code}, 32'd0);
    chk("rst_dout", {22'd0, dout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_conv(tbl[i].mode, tbl[i].vin, tbl[i].exp);
      if (tbl[i].trials) begin
        chk("trial_count", trial_q.size(), 32'd10);
        for (int k = 0; k < 10 && k < trial_q.size(); k++)
          chk("trial_code", {22'd0, trial_q[k]}, {22'd0, 10'h200 >> k});
      end
    end

    // Start held high: back-to-back conversions with one idle cycle.
    mode = 0;
    vin  = 10'h0F0;
    sb.push_back(10'h0F0);
    sb.push_back(10'h0F0);
    d1 = -1;
    d2 = -1;
    lows = 0;
    start = 1'b1;
    for (int i = 0; i < 72; i++) begin
      @(posedge clk); #1;
      if (i == 39) start = 1'b0;
      if (done) begin
        if (d1 < 0) d1 = i;
        else d2 = i;
      end
      if (i > 0 && i < 66 && !busy) lows++;
    end
    chk("held_done1", d1, 32);
    chk("held_done2", d2, 66);
    chk("held_idle_gap", lows, 1);

    // Reset in the middle of bit 5.
    mode = 0;
    vin  = 10'h2A5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    budget = 0;
    while (pulses < 5 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (cmp_en) pulses++;
    end
    chk("abort_reached_bit5", pulses, 5);
    chk("dout_hold_mid", {22'd0, dout}, {22'd0, 10'h0F0});
    dseen = done_seen;
    #2 rst = 1'b1;
    #1;
    chk("arst_sample", {31'd0, sample}, 32'd0);
    chk("arst_cmp_en", {31'd0, cmp_en}, 32'd0);
    chk("arst_dac", {22'd0, dac_code}, 32'd0);
    chk("arst_dout", {22'd0, dout}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_rst", {31'd0, busy}, 32'd0);
    chk("no_done_on_abort", done_seen, dseen);
    run_conv(0, 10'h155, 10'h155);

    // Minimal build: 4 bits, one track cycle, no settle wait.
    s_cmp_cnt = 0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 0;
    while (!s_done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("small_latency", lat, 32'd9);
    chk("small_cmp_pulses", s_cmp_cnt, 32'd4);
    chk("small_dout", {28'd0, s_dout}, {28'd0, 4'hA});
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sar_ctrl.md
SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 Parameter NBITS, default 10: conversion resolution in bits, legal range 2..16.
REQ-002 Parameter SAMPLE_CYC, default 2: number of track phase cycles, at least 1.
REQ-003 Parameter CMP_WAIT, default 1: settle cycles from the comparator strobe to the decision read, at least 0.
REQ-004 Port clk, input, width 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, width 1: reset, asynchronous and active-high.
REQ-006 Port start, input, width 1: conversion request, level-sampled and accepted only in IDLE.
REQ-007 Port cmp_out, input, width 1: comparator decision; 1 means vin > vdac.
REQ-008 Port sample, output, width 1: track-and-hold switch enable, high during track.
REQ-009 Port cmp_en, output, width 1: comparator latch strobe, one-cycle pulse per bit.
REQ-010 Port dac_code, output, width NBITS: trial code to the capacitive DAC.
REQ-011 Port dout, output, width NBITS: last completed conversion result.
REQ-012 Port busy, output, width 1: high in every state except IDLE.
REQ-013 Port done, output, width 1: one-cycle pulse; dout is valid in the same cycle.

Function
REQ-014 FSM states SHALL be IDLE, SAMPLE, STROBE, WAIT, DECIDE and DONE; all outputs SHALL be registered.
REQ-015 IDLE with start=1 SHALL go to SAMPLE, clear dac_code to 0 and load the sample counter.
REQ-016 SAMPLE SHALL hold sample=1 for exactly SAMPLE_CYC cycles.
REQ-017 On leaving SAMPLE, dac_code SHALL become 1<<(NBITS-1), bit pointer = NBITS-1, next state STROBE.
REQ-018 STROBE SHALL drive cmp_en=1 for one cycle, then go to WAIT; if CMP_WAIT=0 it SHALL go directly to DECIDE.
REQ-019 WAIT SHALL last CMP_WAIT cycles, then go to DECIDE.
REQ-020 cmp_out SHALL be read only in DECIDE: dac_code[ptr] keeps its value if cmp_out=1 and is cleared if cmp_out=0.
REQ-021 In DECIDE with ptr>0: set dac_code[ptr-1], decrement ptr, go to STROBE.
REQ-022 In DECIDE with ptr=0: go to DONE and load dout with the final resolved code.
REQ-023 DONE SHALL assert done=1 for one cycle, then go to IDLE; dac_code SHALL hold the final code.
REQ-024 Latency: done high SAMPLE_CYC + NBITS*(2+CMP_WAIT) edges after the edge that accepted start (32 with defaults).
REQ-025 start SHALL be ignored in every state except IDLE, including DONE; no queuing.
REQ-026 dout SHALL change only on entry to DONE and hold otherwise.
REQ-027 cmp_en and sample SHALL never be high in the same cycle.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, sample=0, cmp_en=0, dac_code=0, dout=0, busy=0, done=0 and ptr=0.
REQ-029 Reset mid-conversion SHALL discard the partial result with no done pulse; after release the block SHALL wait for a new start.

Structure
REQ-030 The state enum and default parameter constants (NBITS, SAMPLE_CYC, CMP_WAIT) SHALL live in shared package sar_pkg.
REQ-031 The block SHALL be a single module; no sub-module is required.

Verification
REQ-032 Bench comparator model cmp_out = (vin_code > dac_code) or (vin_code == dac_code and trial bit set); vin_code = 0x2A5 -> dout = 0x2A5, done on edge 32.
REQ-033 cmp_out tied 1 -> dout = 0x3FF; cmp_out tied 0 -> dout = 0x000; dac_code trial sequence with cmp_out=0 is 0x200, 0x100, ..., 0x001.
REQ-034 start held high for 40 cycles -> exactly one conversion plus a second started from IDLE after done; busy low for exactly one cycle between them.
REQ-035 rst pulsed at bit 5 of a conversion -> all outputs 0 asynchronously, no done; the next start converts 0x155 correctly.
REQ-036 With SAMPLE_CYC=1, CMP_WAIT=0, NBITS=4 -> done on edge 9; cmp_en pulses exactly 4 times.
REQ-037 Assertion checks throughout: sample and cmp_en are never both high, and done is never high for two consecutive cycles.
